// File: rtl/timing_decode.sv
// Video timing decoder: measures active resolution and line period from hsync/vsync/DE and locks once timing is stable.
// Define TIMING_DECODE_ERRCNT_EN to enable the saturating lock-loss counter on errorCount.

module timing_decode #(
   parameter int busWidth   = 11,
   parameter int lockFrames = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                hSyncPulse,
   input  logic                vSyncPulse,
   input  logic                dataEnable,
   output logic [busWidth-1:0] pixelX,
   output logic [busWidth-1:0] pixelY,
   output logic [busWidth-1:0] resHorizontal,
   output logic [busWidth-1:0] resVertical,
   output logic [busWidth-1:0] hTotal,
   output logic                frameStart,
   output logic                locked,
   output logic [7:0]          errorCount
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} lockState_t;

   localparam logic [busWidth-1:0] countMax = '1;

   function automatic logic [busWidth-1:0] satInc(input logic [busWidth-1:0] value);
      return (value == countMax) ? value : value + busWidth'(1);
   endfunction

   logic                hSync_p0, vSync_p0, deQual_p0;
   logic                deQual, hsRise, vsRise, deFall;
   logic [busWidth-1:0] hCount, firstWidth, prevWidth, prevHeight;
   logic [busWidth-1:0] lineNext, widthNext;
   logic                hSeen, frameOpen, frameBad, prevValid;
   logic                badNext, frameOk, sameAsPrev;
   lockState_t          state, stateNext;
   logic [3:0]          matchCount, matchNext;

   // DE seen during vsync never counts as active video.
   assign deQual = dataEnable & ~vSyncPulse;
   assign hsRise = hSyncPulse & ~hSync_p0;
   assign vsRise = vSyncPulse & ~vSync_p0;
   assign deFall = ~deQual & deQual_p0;

   // Frame totals as they stand including a line that closes on this very cycle.
   assign lineNext  = deFall ? satInc(pixelY) : pixelY;
   assign widthNext = (deFall && pixelY == '0) ? pixelX : firstWidth;
   assign badNext   = frameBad
                    | (deQual & (pixelX == countMax))
                    | (deFall & (pixelY == countMax))
                    | (deFall & (pixelY != '0) & (pixelX != firstWidth))
                    | (hSeen & ~hsRise & (hCount == countMax));
   assign frameOk    = frameOpen & ~badNext & (lineNext != '0);
   assign sameAsPrev = prevValid & (widthNext == prevWidth) & (lineNext == prevHeight);

   // Stage p0: input copies, counters and per-frame measurement.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hSync_p0      <= 1'b0;
         vSync_p0      <= 1'b0;
         deQual_p0     <= 1'b0;
         frameStart    <= 1'b0;
         hCount        <= '0;
         hSeen         <= 1'b0;
         hTotal        <= '0;
         pixelX        <= '0;
         pixelY        <= '0;
         firstWidth    <= '0;
         frameBad      <= 1'b0;
         frameOpen     <= 1'b0;
         prevWidth     <= '0;
         prevHeight    <= '0;
         prevValid     <= 1'b0;
         resHorizontal <= '0;
         resVertical   <= '0;
      end else begin
         hSync_p0   <= hSyncPulse;
         vSync_p0   <= vSyncPulse;
         deQual_p0  <= deQual;
         frameStart <= vsRise;

         if (hsRise) begin
            if (hSeen) hTotal <= hCount;
            hCount <= busWidth'(1);
            hSeen  <= 1'b1;
         end else begin
            hCount <= satInc(hCount);
         end

         pixelX <= deQual ? satInc(pixelX) : '0;

         if (vsRise) begin
            pixelY     <= '0;
            firstWidth <= '0;
            frameBad   <= 1'b0;
            frameOpen  <= 1'b1;
            if (frameOk) begin
               resHorizontal <= widthNext;
               resVertical   <= lineNext;
            end
            if (frameOpen) begin
               prevWidth  <= widthNext;
               prevHeight <= lineNext;
               prevValid  <= frameOk;
            end
         end else begin
            pixelY     <= lineNext;
            firstWidth <= widthNext;
            frameBad   <= badNext;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         matchCount <= '0;
      end else begin
         state      <= stateNext;
         matchCount <= matchNext;
      end
   end

   always_comb begin
      stateNext = state;
      matchNext = matchCount;
      if (vsRise) begin
         case (state)
            SEARCH: begin
               stateNext = MEASURE;
               matchNext = '0;
            end
            MEASURE: begin
               if (frameOk && sameAsPrev) begin
                  if (({1'b0, matchCount} + 5'd1) >= 5'(lockFrames)) begin
                     stateNext = LOCKED;
                     matchNext = 4'(lockFrames);
                  end else begin
                     matchNext = matchCount + 4'd1;
                  end
               end else begin
                  matchNext = 4'd1;
               end
            end
            LOCKED: begin
               if (!(frameOk && sameAsPrev)) begin
                  stateNext = SEARCH;
                  matchNext = '0;
               end
            end
            default: stateNext = SEARCH;
         endcase
      end
   end

   assign locked = (state == LOCKED);

`ifdef TIMING_DECODE_ERRCNT_EN
   logic lockLoss;
   assign lockLoss = (state == LOCKED) && (stateNext == SEARCH);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         errorCount <= '0;
      end else if (lockLoss && errorCount != 8'hFF) begin
         errorCount <= errorCount + 8'd1;
      end
   end
`else
   assign errorCount = '0;
`endif

endmodule

// File: tb/tb_timing_decode.sv
// Bench for timing_decode: table of frames driven back to back, with results at each frameStart checked from a scoreboard.
// Lines are 24 clocks (hsync free-running), nominal active area 16x12; busWidth 8 keeps saturation reachable.

module tb_timing_decode;

   localparam int BW   = 8;
   localparam int HTOT = 24;

   logic          clock;
   logic          reset_n;
   logic          hSyncPulse, vSyncPulse, dataEnable;
   logic [BW-1:0] pixelX, pixelY, resHorizontal, resVertical, hTotal;
   logic          frameStart, locked;
   logic [7:0]    errorCount;

   timing_decode #(.busWidth(BW), .lockFrames(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .hSyncPulse(hSyncPulse), .vSyncPulse(vSyncPulse), .dataEnable(dataEnable),
      .pixelX(pixelX), .pixelY(pixelY),
      .resHorizontal(resHorizontal), .resVertical(resVertical), .hTotal(hTotal),
      .frameStart(frameStart), .locked(locked), .errorCount(errorCount)
   );

   typedef struct {
      int width; int lines; int badLine; int badWidth; int vsWidth;
      bit coinc; bit checkPix; int resetAt;
      int expResH; int expResV; bit expLocked; int expErr;
   } vec_t;

   typedef struct { int resH; int resV; int hTot; bit lock; int err; } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   bit   rstPending = 0;
   vec_t tbl[14];
   vec_t rst[4];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_pixelX"},        int'(pixelX), 0);
      check({tag, "_pixelY"},        int'(pixelY), 0);
      check({tag, "_resHorizontal"}, int'(resHorizontal), 0);
      check({tag, "_resVertical"},   int'(resVertical), 0);
      check({tag, "_hTotal"},        int'(hTotal), 0);
      check({tag, "_frameStart"},    int'(frameStart), 0);
      check({tag, "_locked"},        int'(locked), 0);
      check({tag, "_errorCount"},    int'(errorCount), 0);
   endtask

   function automatic vec_t mk(input int width, input int lines, input int badLine, input int badWidth,
                               input int vsWidth, input bit coinc, input bit checkPix, input int resetAt,
                               input int eh, input int ev, input bit el, input int errWhenEnabled);
      vec_t v;
      v.width = width; v.lines = lines; v.badLine = badLine; v.badWidth = badWidth;
      v.vsWidth = vsWidth; v.coinc = coinc; v.checkPix = checkPix; v.resetAt = resetAt;
      v.expResH = eh; v.expResV = ev; v.expLocked = el;
`ifdef TIMING_DECODE_ERRCNT_EN
      v.expErr = errWhenEnabled;
`else
      v.expErr = 0 * errWhenEnabled;
`endif
      return v;
   endfunction

   // Vsync phase (expectations for the previous body queued here), then the active body.
   task automatic runEntry(input vec_t v);
      exp_t e;
      for (int c = 0; c < 2 * HTOT; c++) begin
         @(negedge clock);
         if (c == 0) begin
            e.resH = v.expResH; e.resV = v.expResV; e.hTot = HTOT;
            e.lock = v.expLocked; e.err = v.expErr;
            sbq.push_back(e);
         end
         vSyncPulse = (c < v.vsWidth);
         dataEnable = 1'b0;
      end
      for (int ln = 0; ln < v.lines; ln++) begin
         int w;
         bit last;
         w = (ln == v.badLine) ? v.badWidth : v.width;
         last = v.coinc && (ln == v.lines - 1);
         for (int c = 0; c < HTOT; c++) begin
            @(negedge clock);
            if (rstPending) begin
               reset_n = 1'b1;
               rstPending = 1'b0;
            end
            if (v.checkPix && !last && c == 11) begin
               check("pixelX_mid", int'(pixelX), 7);
               check("pixelY_line", int'(pixelY), ln);
            end
            vSyncPulse = 1'b0;
            dataEnable = last ? (c >= HTOT - w) : (c >= 4 && c < 4 + w);
            if (ln == v.resetAt && c == 14) begin
               check("preReset_pixelX", int'(pixelX), 10);
               #2 reset_n = 1'b0;
               #1 checkAllZero("asyncReset");
               rstPending = 1'b1;
            end
         end
      end
      if (!v.coinc) begin
         repeat (HTOT) begin
            @(negedge clock);
            dataEnable = 1'b0;
         end
      end
   endtask

   initial begin
      hSyncPulse = 1'b0;
      forever begin
         for (int c = 0; c < HTOT; c++) begin
            @(negedge clock);
            hSyncPulse = (c < 2);
         end
      end
   end

   // Scoreboard consumer: one expectation per frameStart, and the pulse must be one cycle wide.
   initial begin
      bit   prevFs;
      bit   widthPending;
      exp_t e;
      prevFs = 1'b0;
      widthPending = 1'b0;
      forever begin
         @(negedge clock);
         if (widthPending) begin
            check("frameStartWidth", int'(frameStart), 0);
            widthPending = 1'b0;
         end
         if (frameStart && !prevFs) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpectedFrameStart actual=pulse required=none");
            end else begin
               e = sbq.pop_front();
               check("resHorizontal", int'(resHorizontal), e.resH);
               check("resVertical",   int'(resVertical),   e.resV);
               check("hTotal",        int'(hTotal),        e.hTot);
               check("locked",        int'(locked),        int'(e.lock));
               check("errorCount",    int'(errorCount),    e.err);
            end
            widthPending = 1'b1;
         end
         prevFs = frameStart;
      end
   end

   initial begin
      reset_n    = 1'b0;
      vSyncPulse = 1'b0;
      dataEnable = 1'b0;

      //            w   lines bad bw vs coinc pix rstAt  resH resV lock err
      tbl[0]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,   0,  0, 0, 0);
      tbl[1]  = mk(16, 12,  -1, 0, 3, 0, 1, -1,  16, 12, 0, 0);
      tbl[2]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 1, 0);
      tbl[3]  = mk(16, 12,  -1, 0, 5, 0, 0, -1,  16, 12, 1, 0);
      tbl[4]  = mk(16, 12,   5, 15, 3, 0, 0, -1, 16, 12, 1, 0);
      tbl[5]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 0, 1);
      tbl[6]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 0, 1);
      tbl[7]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 0, 1);
      tbl[8]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 1, 1);
      tbl[9]  = mk(16, 260, -1, 0, 3, 0, 0, -1,  16, 12, 1, 1);
      tbl[10] = mk(16, 20,  -1, 0, 3, 1, 0, -1,  16, 12, 0, 2);
      tbl[11] = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 20, 0, 2);
      tbl[12] = mk(16, 12,  -1, 0, 1, 0, 0, -1,  16, 12, 0, 2);
      tbl[13] = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 1, 2);

      rst[0]  = mk(16, 12,  -1, 0, 3, 0, 0, 3,   16, 12, 1, 2);
      rst[1]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,   0,  0, 0, 0);
      rst[2]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 0, 0);
      rst[3]  = mk(16, 12,  -1, 0, 3, 0, 0, -1,  16, 12, 1, 0);

      repeat (3) @(negedge clock);
      checkAllZero("resetState");
      reset_n = 1'b1;
      repeat (60) @(negedge clock);

      for (int i = 0; i < 14; i++) runEntry(tbl[i]);

      // Mid-line reset, then re-lock after two complete frames.
      for (int i = 0; i < 4; i++) runEntry(rst[i]);

      repeat (10) @(negedge clock);
      check("scoreboardEmpty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timing_decode.md
TIMING_DECODE -- requirements
Module: timing_decode

Interface
REQ-001 Parameter busWidth, default 11, width of all counters and measured resolutions.
REQ-002 Parameter lockFrames, default 2, number of consecutive identical frames required to assert locked (legal 2-15).
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 hSyncPulse  input  1  incoming horizontal sync, active-high.
REQ-006 vSyncPulse  input  1  incoming vertical sync, active-high.
REQ-007 dataEnable  input  1  incoming active-video qualifier, active-high.
REQ-008 pixelX  output  busWidth  index of current active pixel within line.
REQ-009 pixelY  output  busWidth  index of current active line within frame.
REQ-010 resHorizontal  output  busWidth  measured active pixels per line.
REQ-011 resVertical  output  busWidth  measured active lines per frame.
REQ-012 hTotal  output  busWidth  measured clocks between hSyncPulse rising edges.
REQ-013 frameStart  output  1  one-cycle pulse on vSyncPulse rising edge.
REQ-014 locked  output  1  timing stable for lockFrames consecutive frames.
REQ-015 errorCount  output  8  count of lock losses (see Configuration).

Function
REQ-016 Edges detected from one registered copy of each sync/enable input; no input synchroniser inside the block.
REQ-017 Each cycle with dataEnable=1, pixelX shows the count of earlier DE-high cycles in the line, then increments; pixelX returns to 0 on dataEnable falling edge.
REQ-018 On dataEnable falling edge, the line width (DE-high cycle count) is captured internally and the line counter increments; pixelY equals this line counter.
REQ-019 Within one frame, any line width differing from the first line width of that frame marks the frame invalid.
REQ-020 On vSyncPulse rising edge: frameStart=1 for exactly one cycle, line counter and pixelY clear to 0, frame width/height compared against previous frame.
REQ-021 resHorizontal/resVertical update only on vSyncPulse rising edge, one cycle after the edge is sampled, and only if the frame is valid and nonzero height.
REQ-022 hTotal updates on each hSyncPulse rising edge with clocks since the previous rising edge; first edge after reset loads nothing.
REQ-023 All counters saturate at all-ones; saturation marks the current frame invalid.
REQ-024 Simultaneous dataEnable falling edge and vSyncPulse rising edge: line counted first, so resVertical includes that line.
REQ-025 Lock FSM states SEARCH, MEASURE, LOCKED; SEARCH->MEASURE on first vSyncPulse rising edge.
REQ-026 MEASURE: match counter increments per valid frame equal to previous; mismatch or invalid frame reloads count to 1; reaching lockFrames moves to LOCKED and sets locked=1.
REQ-027 LOCKED: any invalid or mismatching frame -> SEARCH, locked=0 same cycle as frameStart.
REQ-028 dataEnable high during vSyncPulse high is ignored for counting.

Reset
REQ-029 reset_n low: all outputs 0, FSM in SEARCH, all counters and captured values 0, immediately and asynchronously.
REQ-030 Reset release mid-frame: the partial frame is discarded; measurement begins at next vSyncPulse rising edge.

Configuration
REQ-031 Macro TIMING_DECODE_ERRCNT_EN defined: errorCount increments (saturating at 255) on each LOCKED->SEARCH transition.
REQ-032 Macro undefined: errorCount port present, constant 0, no counter logic.

Verification
REQ-033 Three frames of 1920x1080 DE, hTotal 2200 -> resHorizontal=1920, resVertical=1080, hTotal=2200, locked=1 after second frame's vsync edge.
REQ-034 Locked, then one line with 1919 DE cycles -> locked=0 at next frameStart, errorCount=1 with macro, 0 without.
REQ-035 Frame with 2100 lines (busWidth=11 saturates at 2047) -> frame invalid, resVertical unchanged, not locked.
REQ-036 DE falling edge coincident with vsync rising edge, 720 lines -> resVertical=720.
REQ-037 reset_n pulsed low mid-line at pixelX=500 -> all outputs 0 immediately; re-lock after two full frames.
REQ-038 frameStart checked as exactly one cycle wide for vsync pulse widths 1 and 5 clocks.
